threshold_event_detector: RTL and testbench
===========================================

// Module: threshold_event_detector
// PURPOSE
//   Downstream consumer of the 4-bit magnitude comparator. Compares a stream of
//   4-bit samples against a loadable threshold and debounces the agb/eq/alb
//   results into a BELOW/ABOVE state with rise/fall event pulses. Keeps a
//   saturating count of confirmed crossings.
// PARAMETERS
//   DEBOUNCE  3  consecutive same-direction samples needed to change state (1..15)
//   CNT_W     8  width of the crossing-event counter
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   thr_load     in   1      load thr_in into the threshold register
//   thr_in       in   4      new threshold value
//   sample_valid in   1      sample is valid this cycle
//   sample       in   4      sample value (comparator operand a; threshold is b)
//   state_o      out  2      00 UNKNOWN, 01 BELOW, 10 ABOVE (11 unused)
//   rise_pulse   out  1      1-cycle pulse on confirmed BELOW->ABOVE
//   fall_pulse   out  1      1-cycle pulse on confirmed ABOVE->BELOW
//   eq_hit       out  1      registered (sample_valid & eq)
//   event_cnt    out  CNT_W  number of confirmed crossings, saturating
// BEHAVIOUR
//   - Reset (async, rst=1): thr=4'b0000, state=UNKNOWN, run=0, all outputs 0.
//   - The comparator is combinational on (sample, thr). All outputs are registered.
//     The response appears on the clk edge that samples sample_valid.
//   - thr_load has priority. On that edge: thr<=thr_in, state<=UNKNOWN, run<=0.
//     A sample_valid in the same cycle is ignored and produces no pulses.
//   - UNKNOWN + valid:
//       agb -> ABOVE, alb -> BELOW, eq -> stay.
//       No pulse and no count on leaving UNKNOWN.
//   - BELOW + valid:
//       agb: if run==DEBOUNCE-1 then state<=ABOVE, rise_pulse<=1, run<=0,
//            event_cnt++; else run++.
//       alb or eq: run<=0 (eq is a deadband and breaks the streak).
//   - ABOVE + valid: mirror of BELOW using alb, with fall_pulse.
//   - No sample_valid: state and run hold. Pulses and eq_hit return to 0.
//   - Pulses are high for exactly one cycle. Back-to-back crossings are only
//     possible with DEBOUNCE=1, and then the pulses alternate.
//   - DEBOUNCE=1: the first opposite sample switches state immediately.
//   - event_cnt saturates at all-ones and never wraps. thr_load does not clear it.
//   - run is 4 bits. Out-of-range DEBOUNCE is a synthesis-time error
//     (generate-time check).
//   - Reset asserted mid-streak clears run and state immediately, with no pulse.
// STRUCTURE
//   - Shared package/header: state encodings ST_UNKNOWN/ST_BELOW/ST_ABOVE
//     (2-bit localparams) and the 4-bit data width constant.
//   - One sub-module: four_bit_comparator (a=sample, b=thr -> agb/eq/alb),
//     instantiated unmodified.
//   - Top level contains: thr register, run counter, 2-bit state FSM,
//     output registers and the saturating event counter.
// TESTING
//   1. rst=1 then 0, no stimulus -> state_o=00, all pulses 0, event_cnt=0,
//      thr=0. Assert rst mid-run -> all outputs 0 asynchronously.
//   2. Load thr=4'b1000. Samples 2,3 -> BELOW. Then samples 9,9,9 (DEBOUNCE=3)
//      -> rise_pulse one cycle after the 3rd, state_o=10, event_cnt=1.
//   3. In ABOVE with thr=8: samples 1,1,8,1,1,1 -> eq at the 3rd breaks the run.
//      fall_pulse only after the 6th; eq_hit=1 exactly at the 3rd.
//   4. thr_load and sample_valid in the same cycle -> sample ignored,
//      state_o=00, no pulse. The next sample 4'b1111 vs new thr=4'b0001 -> ABOVE.
//   5. CNT_W=2, DEBOUNCE=1: alternate samples 0,15 around thr=8 for 6 crossings
//      -> alternating pulses, event_cnt sticks at 2'b11.
//   6. Gaps (sample_valid=0) inside a streak 9,-,9,-,9 -> run holds;
//      rise_pulse occurs after the 3rd valid sample.

Source files
------------

// File: rtl/threshold_event_detector_pkg.sv
// Shared definitions for the threshold event detector.
//   DATA_W                          width of samples and threshold
//   ST_UNKNOWN / ST_BELOW / ST_ABOVE  2-bit encodings driven on state_o
//   state_t                         FSM state type built on those encodings
package threshold_event_detector_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] ST_UNKNOWN = 2'b00;
  localparam logic [1:0] ST_BELOW   = 2'b01;
  localparam logic [1:0] ST_ABOVE   = 2'b10;

  typedef enum logic [1:0] {
    S_UNKNOWN = ST_UNKNOWN,
    S_BELOW   = ST_BELOW,
    S_ABOVE   = ST_ABOVE
  } state_t;

endpackage

// File: rtl/threshold_event_detector_if.sv
// Sample/threshold bus of the threshold event detector.
//   master : drives thr_load, thr_in, sample_valid, sample; observes results
//   slave  : the detector; receives the inputs and drives state_o, rise_pulse,
//            fall_pulse, eq_hit and event_cnt (CNT_W bits)
interface threshold_event_detector_if #(
  parameter int CNT_W = 8
);
  import threshold_event_detector_pkg::*;

  logic              thr_load;
  logic [DATA_W-1:0] thr_in;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [1:0]        state_o;
  logic              rise_pulse;
  logic              fall_pulse;
  logic              eq_hit;
  logic [CNT_W-1:0]  event_cnt;

  modport master (
    output thr_load, thr_in, sample_valid, sample,
    input  state_o, rise_pulse, fall_pulse, eq_hit, event_cnt
  );

  modport slave (
    input  thr_load, thr_in, sample_valid, sample,
    output state_o, rise_pulse, fall_pulse, eq_hit, event_cnt
  );

endinterface

// File: rtl/threshold_event_detector_comparator.sv
// Combinational 4-bit magnitude comparator.
//   a, b : operands (DATA_W bits)
//   agb  : a > b     eq : a == b     alb : a < b
module four_bit_comparator
  import threshold_event_detector_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              agb,
  output logic              eq,
  output logic              alb
);

  assign agb = (a > b);
  assign eq  = (a == b);
  assign alb = (a < b);

endmodule

// File: rtl/threshold_event_detector.sv
// Debounced threshold crossing detector.
// Compares each valid sample against a loadable threshold, requires DEBOUNCE
// consecutive opposite-side samples to confirm a crossing, emits one-cycle
// rise/fall pulses and keeps a saturating count of confirmed crossings.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of threshold_event_detector_if (inputs thr_load, thr_in,
//         sample_valid, sample; outputs state_o, rise_pulse, fall_pulse,
//         eq_hit, event_cnt)
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_UNKNOWN | after reset or threshold load; first non-equal sample decides
// S_BELOW   | confirmed below threshold; counting consecutive above samples
// S_ABOVE   | confirmed above threshold; counting consecutive below samples
module threshold_event_detector
  import threshold_event_detector_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  threshold_event_detector_if.slave   bus
);

  if ((DEBOUNCE < 1) || (DEBOUNCE > 15)) begin : g_debounce_range
    $error("DEBOUNCE must be within 1..15");
  end

  localparam logic [3:0] RUN_LAST = 4'(DEBOUNCE - 1);

  state_t            state, state_nxt;
  logic [3:0]        run, run_nxt;
  logic [DATA_W-1:0] thr, thr_nxt;
  logic              rise, rise_nxt;
  logic              fall, fall_nxt;
  logic              eq_hit, eq_hit_nxt;
  logic              cnt_inc;
  logic [CNT_W-1:0]  cnt;
  logic              agb, eq, alb;

  four_bit_comparator u_cmp (
    .a   (bus.sample),
    .b   (thr),
    .agb (agb),
    .eq  (eq),
    .alb (alb)
  );

  always_comb begin
    state_nxt  = state;
    run_nxt    = run;
    thr_nxt    = thr;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    eq_hit_nxt = 1'b0;
    cnt_inc    = 1'b0;
    if (bus.thr_load) begin
      // A sample arriving together with a new threshold is dropped entirely.
      thr_nxt   = bus.thr_in;
      state_nxt = S_UNKNOWN;
      run_nxt   = '0;
    end else if (bus.sample_valid) begin
      eq_hit_nxt = eq;
      case (state)
        S_UNKNOWN: begin
          if (agb)      state_nxt = S_ABOVE;
          else if (alb) state_nxt = S_BELOW;
        end
        S_BELOW: begin
          if (agb) begin
            if (run == RUN_LAST) begin
              state_nxt = S_ABOVE;
              rise_nxt  = 1'b1;
              run_nxt   = '0;
              cnt_inc   = 1'b1;
            end else begin
              run_nxt = run + 4'd1;
            end
          end else begin
            // equal is a deadband: it breaks the streak just like below
            run_nxt = '0;
          end
        end
        S_ABOVE: begin
          if (alb) begin
            if (run == RUN_LAST) begin
              state_nxt = S_BELOW;
              fall_nxt  = 1'b1;
              run_nxt   = '0;
              cnt_inc   = 1'b1;
            end else begin
              run_nxt = run + 4'd1;
            end
          end else begin
            run_nxt = '0;
          end
        end
        default: begin
          state_nxt = S_UNKNOWN;
          run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_UNKNOWN;
      run    <= '0;
      thr    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      eq_hit <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      run    <= run_nxt;
      thr    <= thr_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
      eq_hit <= eq_hit_nxt;
      if (cnt_inc && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.state_o    = state;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.eq_hit     = eq_hit;
  assign bus.event_cnt  = cnt;

endmodule

// File: tb/tb_threshold_event_detector.sv
module tb_threshold_event_detector;
  import threshold_event_detector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       thr_load;
  logic [3:0] thr_in;
  logic       sample_valid;
  logic [3:0] sample;

  threshold_event_detector_if #(.CNT_W(8)) bus_a ();
  threshold_event_detector_if #(.CNT_W(2)) bus_b ();

  assign bus_a.thr_load     = thr_load;
  assign bus_a.thr_in       = thr_in;
  assign bus_a.sample_valid = sample_valid;
  assign bus_a.sample       = sample;
  assign bus_b.thr_load     = thr_load;
  assign bus_b.thr_in       = thr_in;
  assign bus_b.sample_valid = sample_valid;
  assign bus_b.sample       = sample;

  threshold_event_detector #(.DEBOUNCE(3), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  threshold_event_detector #(.DEBOUNCE(1), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Reference: side 0 unknown, 1 below, 2 above; streak = consecutive
  // valid samples on the opposite side of the current confirmed side.
  typedef struct {
    int side;
    int streak;
    int rise;
    int fall;
    int eqh;
    int cnt;
    int thr;
  } mdl_t;

  mdl_t ma, mb;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  function automatic mdl_t mdl_step(mdl_t m, int deb, int cmax,
                                    bit ld, int ti, bit v, int s);
    mdl_t n;
    bit   opposite;
    n      = m;
    n.rise = 0;
    n.fall = 0;
    n.eqh  = 0;
    if (ld) begin
      n.thr    = ti;
      n.side   = 0;
      n.streak = 0;
    end else if (v) begin
      n.eqh = (s == m.thr) ? 1 : 0;
      if (m.side == 0) begin
        n.side = (s > m.thr) ? 2 : ((s < m.thr) ? 1 : 0);
      end else begin
        opposite = (m.side == 1) ? (s > m.thr) : (s < m.thr);
        if (!opposite) begin
          n.streak = 0;
        end else if (m.streak + 1 >= deb) begin
          n.streak = 0;
          n.side   = 3 - m.side;
          if (m.side == 1) n.rise = 1;
          else             n.fall = 1;
          n.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
        end else begin
          n.streak = m.streak + 1;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_state", 32'(bus_a.state_o),    32'(ma.side));
      chk("a_rise",  32'(bus_a.rise_pulse), 32'(ma.rise));
      chk("a_fall",  32'(bus_a.fall_pulse), 32'(ma.fall));
      chk("a_eqhit", 32'(bus_a.eq_hit),     32'(ma.eqh));
      chk("a_cnt",   32'(bus_a.event_cnt),  32'(ma.cnt));
      chk("b_state", 32'(bus_b.state_o),    32'(mb.side));
      chk("b_rise",  32'(bus_b.rise_pulse), 32'(mb.rise));
      chk("b_fall",  32'(bus_b.fall_pulse), 32'(mb.fall));
      chk("b_eqhit", 32'(bus_b.eq_hit),     32'(mb.eqh));
      chk("b_cnt",   32'(bus_b.event_cnt),  32'(mb.cnt));
    end
  end

  // Apply one cycle of stimulus starting from a falling edge.
  task automatic step(bit ld, int ti, bit v, int s);
    thr_load     = ld;
    thr_in       = 4'(ti);
    sample_valid = v;
    sample       = 4'(s);
    @(posedge clk);
    ma = mdl_step(ma, 3, 255, ld, ti, v, s);
    mb = mdl_step(mb, 1, 3,   ld, ti, v, s);
    @(negedge clk);
  endtask

  task automatic smp(int s);
    step(1'b0, 0, 1'b1, s);
  endtask

  initial begin
    thr_load     = 1'b0;
    thr_in       = '0;
    sample_valid = 1'b0;
    sample       = '0;
    ma = '{default: 0};
    mb = '{default: 0};
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // reset state; threshold 0 shows up as eq_hit on a zero sample
    chk("rst_state", 32'(bus_a.state_o), 32'd0);
    chk("rst_cnt",   32'(bus_a.event_cnt), 32'd0);
    smp(0);
    chk("thr0_eqhit", 32'(bus_a.eq_hit), 32'd1);
    chk("thr0_state", 32'(bus_a.state_o), 32'd0);
    smp(5);
    chk("unk_above", 32'(bus_a.state_o), 32'd2);

    // below, then three above samples confirm a rise
    step(1'b1, 8, 1'b0, 0);
    chk("load_unknown", 32'(bus_a.state_o), 32'd0);
    smp(2);
    smp(3);
    chk("below", 32'(bus_a.state_o), 32'd1);
    smp(9);
    smp(9);
    chk("rise_early", 32'(bus_a.rise_pulse), 32'd0);
    smp(9);
    chk("rise_pulse", 32'(bus_a.rise_pulse), 32'd1);
    chk("rise_state", 32'(bus_a.state_o), 32'd2);
    chk("rise_cnt",   32'(bus_a.event_cnt), 32'd1);
    step(1'b0, 0, 1'b0, 0);
    chk("rise_oneshot", 32'(bus_a.rise_pulse), 32'd0);

    // equal sample breaks the falling streak
    smp(1);
    smp(1);
    smp(8);
    chk("eq_hit_mid", 32'(bus_a.eq_hit), 32'd1);
    smp(1);
    smp(1);
    chk("fall_early", 32'(bus_a.fall_pulse), 32'd0);
    chk("eq_hit_off", 32'(bus_a.eq_hit), 32'd0);
    smp(1);
    chk("fall_pulse", 32'(bus_a.fall_pulse), 32'd1);
    chk("fall_state", 32'(bus_a.state_o), 32'd1);
    chk("fall_cnt",   32'(bus_a.event_cnt), 32'd2);

    // load and sample together: sample dropped
    step(1'b1, 1, 1'b1, 15);
    chk("ldv_state", 32'(bus_a.state_o), 32'd0);
    chk("ldv_rise",  32'(bus_b.rise_pulse), 32'd0);
    smp(15);
    chk("ldv_next", 32'(bus_a.state_o), 32'd2);

    // gaps inside a streak hold the run
    step(1'b1, 8, 1'b0, 0);
    smp(2);
    smp(9);
    step(1'b0, 0, 1'b0, 9);
    smp(9);
    step(1'b0, 0, 1'b0, 9);
    chk("gap_nopulse", 32'(bus_a.rise_pulse), 32'd0);
    smp(9);
    chk("gap_rise", 32'(bus_a.rise_pulse), 32'd1);
    chk("gap_cnt",  32'(bus_a.event_cnt), 32'd3);

    // DEBOUNCE=1 instance: alternating crossings, counter sticks at 3
    step(1'b1, 8, 1'b0, 0);
    smp(0);
    smp(15);
    chk("b_alt_rise", 32'(bus_b.rise_pulse), 32'd1);
    smp(0);
    chk("b_alt_fall", 32'(bus_b.fall_pulse), 32'd1);
    for (int i = 0; i < 4; i++) smp((i % 2 == 0) ? 15 : 0);
    chk("b_cnt_sat", 32'(bus_b.event_cnt), 32'd3);

    // asynchronous reset in the middle of a streak and a live pulse
    smp(9);
    chk("pre_rst_rise", 32'(bus_b.rise_pulse), 32'd1);
    sample_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(bus_a.state_o), 32'd0);
    chk("arst_cnt",   32'(bus_a.event_cnt), 32'd0);
    chk("arst_rise",  32'(bus_b.rise_pulse), 32'd0);
    chk("arst_bcnt",  32'(bus_b.event_cnt), 32'd0);
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
